rx_prbs_checker_16b: RTL and testbench
======================================

Name: rx_prbs_checker_16b

Overview:
- Receive-side counterpart of the TX PRBS source and 16:1 serializer.
- Consumes 16-bit deserialized words from the RX deserializer and self-synchronizes a PRBS predictor to the incoming stream.
- Once synchronized, it flags and counts bit errors against the predicted sequence and reports lock status.
- Used for link BER measurement alongside the TX PRBS generator (same eqn polynomial format).

Parameters:
N_PRBS, 32, PRBS history length in bits; eqn width
WIDTH, 16, bits per received word
LOCK_THRESH, 64, consecutive error-free words needed to declare lock
UNLOCK_THRESH, 8, consecutive errored words (while locked) that force resync
CNT_W, 32, width of bit-error and word counters

Ports:
clk  input  1  checker clock, one word per din_valid
rst_n  input  1  asynchronous active-low reset
en  input  1  checker enable; 0 returns FSM to IDLE, counters hold
din  input  WIDTH  received word; din[15] is earliest bit in time
din_valid  input  1  din is valid this cycle
eqn  input  N_PRBS  tap mask; bit j set means x[k-j-1] is XORed into x[k]
inv_in  input  1  invert din before checking
clear_cnt  input  1  synchronous clear of err_cnt and word_cnt
lock  output  1  predictor locked
err_word  output  1  last checked word had at least one bit error
err_bits  output  5  bit errors in last checked word (0..16)
err_cnt  output  CNT_W  total bit errors while locked, saturating
word_cnt  output  CNT_W  words checked while locked, saturating

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE. History, counters, lock, err_word and err_bits are all 0.
- Prediction: the next WIDTH bits are computed serially in time order from the N_PRBS-bit history via the eqn recursion. Bit 0 of the word is compared against din[15]. The history shift and the predicted word are formed combinationally each valid cycle.
- FSM states:
  - IDLE: when en=1, go to SEED.
  - SEED: shift the received bits into history on each din_valid. After ceil(N_PRBS/WIDTH)=2 valid words, go to LOCK_WAIT.
  - LOCK_WAIT: on each valid word, compare predicted vs received. History keeps loading from received bits (self-sync).
    - An error-free word increments clean_cnt; any error clears it.
    - When clean_cnt reaches LOCK_THRESH, go to LOCKED and set lock=1 in the same edge.
  - LOCKED: history loads from predicted bits (free-run), so a single channel error is counted once.
    - Each errored word increments bad_cnt; an error-free word clears it.
    - When bad_cnt reaches UNLOCK_THRESH, go to SEED and set lock=0.
  - en=0 in any state: go to IDLE next edge and set lock=0. Counters hold. No checking occurs.
- Cycles without din_valid change no state, counter or output.
- Output timing: err_word and err_bits are registered and update one clock after the valid word, in LOCK_WAIT and LOCKED only. Elsewhere they are 0.
- Counters:
  - They increment only in LOCKED on valid words: word_cnt += 1, err_cnt += err_bits_next.
  - Both saturate at 2^CNT_W-1 with no wrap.
- clear_cnt clears both counters. It takes priority over an increment in the same cycle (result 0). It does not affect FSM or lock.
- The lock-entering word is not counted. Counting starts with the next valid word.
- eqn change while locked: undefined until software clears en, then re-enables.
- inv_in applies to din before both history load and comparison.

Test Plan:
- Reset/idle: hold rst_n=0, then release with en=0 and clean PRBS input -> lock=0, err_cnt=0, word_cnt=0, err_bits=0 indefinitely.
- Acquire lock: en=1, eqn=32'h100002, clean PRBS words every cycle -> lock rises after 2 seed words + 64 clean words. Then 1000 more words -> word_cnt=1000, err_cnt=0.
- Single-bit error while locked: flip din[7] on one word -> err_word=1 and err_bits=1 on the next cycle, err_cnt=1. The following words are clean (free-run), lock stays 1.
- Loss of lock: feed 8 consecutive words of random data while locked -> lock=0 after the 8th. FSM re-seeds, and clean PRBS relocks after 66 words. Counters include only errors from locked words.
- Counter clear/saturation:
  - Assert clear_cnt on the same cycle as an errored word -> err_cnt=0.
  - Preload near max (CNT_W=4 build) -> err_cnt holds at 15.
- Inverted stream and gaps: inverted PRBS with inv_in=1 and din_valid toggling 50% -> locks, err_cnt=0. word_cnt counts only valid words.

Source files
------------

// File: rtl/rx_prbs_checker_16b.sv
// rx_prbs_checker_16b: self-synchronising PRBS checker for 16-bit deserialized words.
// Seeds a predictor from the received stream, then free-runs it once locked to count bit errors.
module rx_prbs_checker_16b #(
    parameter int N_PRBS        = 32,
    parameter int WIDTH         = 16,
    parameter int LOCK_THRESH   = 64,
    parameter int UNLOCK_THRESH = 8,
    parameter int CNT_W         = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    input  logic [N_PRBS-1:0]            eqn,
    input  logic                         inv_in,
    input  logic                         clear_cnt,
    output logic                         lock,
    output logic                         err_word,
    output logic [$clog2(WIDTH+1)-1:0]   err_bits,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [CNT_W-1:0]             word_cnt
);
    localparam int SEED_WORDS = (N_PRBS + WIDTH - 1) / WIDTH;
    localparam int EB_W       = $clog2(WIDTH + 1);
    localparam int SC_W       = $clog2(LOCK_THRESH + UNLOCK_THRESH + SEED_WORDS + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEED = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    logic [1:0]        r_state;
    logic [SC_W-1:0]   r_cnt;
    logic [N_PRBS-1:0] r_hist;
    logic              r_lock;
    logic              r_err_word;
    logic [EB_W-1:0]   r_err_bits;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [N_PRBS-1:0] w_free;
    logic [N_PRBS-1:0] w_rx;
    logic [WIDTH-1:0]  w_din;
    logic [WIDTH-1:0]  w_pred;
    logic [WIDTH-1:0]  w_err;
    logic [EB_W-1:0]   w_nerr;
    logic [SC_W-1:0]   w_lim;
    logic              w_chk;
    logic              w_ev;
    logic              w_fire;
    logic              w_hit;
    logic [CNT_W:0]    w_esum;

    // Predicted bits feed back into the recursion, so w_free is also the free-run next history.
    always_comb begin
        w_din  = inv_in ? ~din : din;
        w_free = r_hist;
        w_pred = '0;
        w_nerr = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_pred[i] = ^(w_free & eqn);
            w_free    = {w_free[N_PRBS-2:0], w_pred[i]};
        end
        w_err = w_pred ^ w_din;
        for (int i = 0; i < WIDTH; i++) w_nerr = w_nerr + EB_W'(w_err[i]);
        w_rx   = {r_hist[N_PRBS-WIDTH-1:0], w_din};
        w_chk  = r_state == S_WAIT || r_state == S_LOCK;
        w_ev   = r_state == S_SEED || (r_state == S_WAIT && w_err == '0) || (r_state == S_LOCK && w_err != '0);
        w_lim  = r_state == S_SEED ? SC_W'(SEED_WORDS - 1) :
                 r_state == S_WAIT ? SC_W'(LOCK_THRESH - 1) : SC_W'(UNLOCK_THRESH - 1);
        w_fire = w_ev && r_cnt == w_lim;
        w_hit  = en && din_valid && r_state == S_LOCK;
        w_esum = {1'b0, r_err_cnt} + (CNT_W+1)'(w_nerr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hist     <= '0;
            r_lock     <= 1'b0;
            r_err_word <= 1'b0;
            r_err_bits <= '0;
        end else if (!en) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lock     <= 1'b0;
            r_err_word <= 1'b0;
            r_err_bits <= '0;
        end else if (r_state == S_IDLE) begin
            r_state <= S_SEED;
            r_cnt   <= '0;
        end else if (din_valid) begin
            r_hist     <= r_state == S_LOCK ? w_free : w_rx;
            r_err_word <= w_chk && w_err != '0;
            r_err_bits <= w_chk ? w_nerr : '0;
            r_cnt      <= w_ev && !w_fire ? r_cnt + SC_W'(1) : '0;
            if (w_fire) begin
                r_state <= r_state == S_SEED ? S_WAIT : r_state == S_WAIT ? S_LOCK : S_SEED;
                r_lock  <= r_state == S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (clear_cnt) begin
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (w_hit) begin
            r_err_cnt  <= w_esum[CNT_W] ? '1 : w_esum[CNT_W-1:0];
            r_word_cnt <= &r_word_cnt ? r_word_cnt : r_word_cnt + CNT_W'(1);
        end
    end

    assign lock     = r_lock;
    assign err_word = r_err_word;
    assign err_bits = r_err_bits;
    assign err_cnt  = r_err_cnt;
    assign word_cnt = r_word_cnt;
endmodule

// File: tb/tb_rx_prbs_checker_16b.sv
// tb_rx_prbs_checker_16b: scoreboard bench; a bit-level model predicts every checked word's outputs.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_rx_prbs_checker_16b;
    localparam logic [31:0] EQN = 32'h0010_0002;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, din_valid = 1'b0, inv_in = 1'b0, clear_cnt = 1'b0;
    logic [15:0] din = '0;
    logic [31:0] eqn = EQN;
    logic        lock, err_word, lock4, ew4;
    logic [4:0]  err_bits, eb4;
    logic [31:0] err_cnt, word_cnt;
    logic [3:0]  ec4, wc4;

    rx_prbs_checker_16b dut (.clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid), .eqn(eqn),
        .inv_in(inv_in), .clear_cnt(clear_cnt), .lock(lock), .err_word(err_word), .err_bits(err_bits),
        .err_cnt(err_cnt), .word_cnt(word_cnt));
    rx_prbs_checker_16b #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .eqn(eqn), .inv_in(inv_in), .clear_cnt(clear_cnt), .lock(lock4), .err_word(ew4), .err_bits(eb4),
        .err_cnt(ec4), .word_cnt(wc4));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        lock;
        logic        ew;
        logic [4:0]  eb;
        logic [31:0] ec;
        logic [31:0] wc;
        logic [3:0]  ec4;
        logic [3:0]  wc4;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] tx_h;
    bit          g_en = 0, g_inv = 0;
    bit          m_h[32];
    int          m_mode = 0, m_n = 0, m_eb = 0;
    bit          m_lock = 0, m_ew = 0;
    longint      m_ec = 0, m_wc = 0, m_ec4 = 0, m_wc4 = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tx_next(output logic [15:0] w);
        logic b;
        for (int t = 0; t < 16; t++) begin
            b        = ^(tx_h & EQN);
            tx_h     = {tx_h[30:0], b};
            w[15-t]  = b;
        end
    endtask

    // Modes: 0 idle, 1 seeding, 2 waiting for lock, 3 locked.
    task automatic model_step();
        logic [15:0] d;
        bit          th[32];
        bit          b;
        int          nb;
        bit          inc;
        inc = 0;
        nb  = 0;
        if (!en) begin
            m_mode = 0; m_n = 0; m_lock = 0; m_ew = 0; m_eb = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_n = 0;
        end else if (din_valid) begin
            d  = inv_in ? ~din : din;
            th = m_h;
            for (int t = 0; t < 16; t++) begin
                b = 0;
                for (int j = 0; j < 32; j++) b ^= eqn[j] & th[j];
                for (int j = 31; j > 0; j--) th[j] = th[j-1];
                th[0] = b;
                if (b != d[15-t]) nb++;
            end
            if (m_mode == 3) m_h = th;
            else for (int t = 0; t < 16; t++) begin
                for (int j = 31; j > 0; j--) m_h[j] = m_h[j-1];
                m_h[0] = d[15-t];
            end
            m_ew = m_mode >= 2 && nb > 0;
            m_eb = m_mode >= 2 ? nb : 0;
            inc  = m_mode == 3;
            if (m_mode == 1) begin
                m_n++;
                if (m_n == 2) begin m_mode = 2; m_n = 0; end
            end else if (m_mode == 2) begin
                if (nb > 0) m_n = 0;
                else begin
                    m_n++;
                    if (m_n == 64) begin m_mode = 3; m_lock = 1; m_n = 0; end
                end
            end else begin
                if (nb == 0) m_n = 0;
                else begin
                    m_n++;
                    if (m_n == 8) begin m_mode = 1; m_lock = 0; m_n = 0; end
                end
            end
        end
        if (clear_cnt) begin
            m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
        end else if (inc) begin
            m_wc  = m_wc + 1 > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_wc + 1;
            m_ec  = m_ec + nb > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_ec + nb;
            m_wc4 = m_wc4 + 1 > 15 ? 15 : m_wc4 + 1;
            m_ec4 = m_ec4 + nb > 15 ? 15 : m_ec4 + nb;
        end
    endtask

    task automatic cyc(bit v, logic [15:0] w, bit clr);
        exp_t e;
        @(negedge clk);
        en = g_en; inv_in = g_inv; din_valid = v; din = w; clear_cnt = clr;
        @(posedge clk);
        model_step();
        if (v) begin
            e.lock = m_lock; e.ew = m_ew; e.eb = 5'(m_eb);
            e.ec = 32'(m_ec); e.wc = 32'(m_wc); e.ec4 = 4'(m_ec4); e.wc4 = 4'(m_wc4);
            q.push_back(e);
        end
    endtask

    task automatic send(bit v, logic [15:0] mask, bit clr);
        logic [15:0] w;
        if (v) begin
            tx_next(w);
            cyc(1'b1, (g_inv ? ~w : w) ^ mask, clr);
        end else cyc(1'b0, 16'($urandom()), clr);
    endtask

    task automatic clean(int n);
        repeat (n) send(1'b1, 16'h0, 1'b0);
    endtask

    always @(posedge clk) begin
        if (din_valid) begin
            exp_t e;
            #1;
            if (q.size() == 0) check("queue_underrun", 1, 0);
            else begin
                e = q.pop_front();
                check("lock", lock, e.lock);
                check("err_word", err_word, e.ew);
                check("err_bits", err_bits, e.eb);
                check("err_cnt", err_cnt, e.ec);
                check("word_cnt", word_cnt, e.wc);
                check("err_cnt4", ec4, e.ec4);
                check("word_cnt4", wc4, e.wc4);
            end
        end
    end

    initial begin
        tx_h = $urandom() | 32'h1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lock", lock, 0);
        check("rst_err_word", err_word, 0);
        check("rst_err_bits", err_bits, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        clean(20);
        g_en = 1;
        send(1'b0, 16'h0, 1'b0);
        clean(65);
        #2 check("no_lock_65", lock, 0);
        clean(1);
        #2 check("lock_66", lock, 1);
        check("lock_word_uncounted", word_cnt, 0);
        clean(1000);
        #2 check("words_1000", word_cnt, 1000);
        check("errs_clean", err_cnt, 0);
        send(1'b1, 16'h0080, 1'b0);
        #2 check("single_err_word", err_word, 1);
        check("single_err_bits", err_bits, 1);
        clean(20);
        #2 check("single_err_cnt", err_cnt, 1);
        check("free_run_lock", lock, 1);
        repeat (7) send(1'b1, 16'($urandom_range(16'hFFFF, 1)), 1'b0);
        #2 check("lock_after_7_bad", lock, 1);
        send(1'b1, 16'($urandom_range(16'hFFFF, 1)), 1'b0);
        #2 check("unlock_after_8_bad", lock, 0);
        clean(66);
        #2 check("relock", lock, 1);
        send(1'b1, 16'(1) << $urandom_range(15), 1'b1);
        #2 check("clear_prio_err", err_cnt, 0);
        check("clear_prio_word", word_cnt, 0);
        send(1'b1, 16'hFFFF, 1'b0);
        #2 check("sat4_first", ec4, 15);
        check("err_cnt_16", err_cnt, 16);
        send(1'b1, 16'h000F, 1'b0);
        #2 check("sat4_hold", ec4, 15);
        check("err_cnt_20", err_cnt, 20);
        clean(5);
        g_en = 0;
        send(1'b0, 16'h0, 1'b0);
        g_inv = 1; g_en = 1;
        send(1'b0, 16'h0, 1'b0);
        repeat (300) send(1'($urandom_range(1)), 16'h0, 1'b0);
        #2 check("inv_lock", lock, 1);
        check("inv_err_cnt", err_cnt, 20);
        repeat (400) send(1'($urandom_range(1)), $urandom_range(39) == 0 ? 16'(1) << $urandom_range(15) : 16'h0,
                          1'($urandom_range(99) == 0));
        repeat (3) send(1'b0, 16'h0, 1'b0);
        #2 check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
